// File: rtl/sdram_rd_port.sv
// SDRAM-side responder for 32-bit ROM read ports: two 16-bit beats per word,
// one queued request, optional last-word cache and a per-beat watchdog.
module sdram_rd_port #(
   parameter int CACHE_EN = 1,
   parameter int TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [24:1] sdr_addr,
   input  logic        sdr_req,
   output logic [31:0] sdr_data,
   output logic        sdr_rdy,
   output logic [24:1] mem_addr,
   output logic        mem_rd,
   input  logic        mem_ack,
   input  logic [15:0] mem_dout,
   input  logic        inval,
   output logic        err,
   output logic        overflow
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RD_LO, RD_HI} state_t;

   state_t        state_q;
   logic [31:0]   sdr_data_q;
   logic          sdr_rdy_q;
   logic [24:1]   mem_addr_q;
   logic          mem_rd_q;
   logic          err_q;
   logic          overflow_q;
   logic          pend_vld_q;
   logic [24:2]   pend_tag_q;
   logic          cache_vld_q;
   logic [24:2]   cache_tag_q;
   logic [31:0]   cache_data_q;
   logic [15:0]   lo_q;
   logic [CW-1:0] cnt_q;

   logic          src_vld;
   logic [24:2]   src_tag;
   logic          cache_hit;

   // Bit 1 only selects a halfword inside the word; requests are word aligned.
   logic unused_addr_bit;
   assign unused_addr_bit = sdr_addr[1];

   // The pending entry is always older than a fresh pulse, so it is served first.
   always_comb begin
      src_vld   = pend_vld_q | sdr_req;
      src_tag   = pend_vld_q ? pend_tag_q : sdr_addr[24:2];
      cache_hit = (CACHE_EN != 0) && cache_vld_q && (cache_tag_q == src_tag) && !inval;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sdr_data_q   <= '0;
         sdr_rdy_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_rd_q     <= 1'b0;
         err_q        <= 1'b0;
         overflow_q   <= 1'b0;
         pend_vld_q   <= 1'b0;
         pend_tag_q   <= '0;
         cache_vld_q  <= 1'b0;
         cache_tag_q  <= '0;
         cache_data_q <= '0;
         lo_q         <= '0;
         cnt_q        <= '0;
      end else begin
         sdr_rdy_q <= 1'b0;
         err_q     <= 1'b0;
         if (inval)
            cache_vld_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (src_vld) begin
                  pend_vld_q <= pend_vld_q & sdr_req;
                  if (pend_vld_q && sdr_req)
                     pend_tag_q <= sdr_addr[24:2];
                  if (cache_hit) begin
                     sdr_rdy_q  <= 1'b1;
                     sdr_data_q <= cache_data_q;
                  end else begin
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= {src_tag, 1'b0};
                     cnt_q      <= '0;
                     state_q    <= RD_LO;
                  end
               end
            end

            RD_LO, RD_HI: begin
               if (sdr_req) begin
                  if (!pend_vld_q) begin
                     pend_vld_q <= 1'b1;
                     pend_tag_q <= sdr_addr[24:2];
                  end else begin
                     overflow_q <= 1'b1;
                  end
               end

               // An ack on the expiry cycle still wins over the watchdog.
               if (mem_ack) begin
                  cnt_q <= '0;
                  if (state_q == RD_LO) begin
                     lo_q          <= mem_dout;
                     mem_addr_q[1] <= 1'b1;
                     state_q       <= RD_HI;
                  end else begin
                     sdr_data_q <= {mem_dout, lo_q};
                     sdr_rdy_q  <= 1'b1;
                     mem_rd_q   <= 1'b0;
                     state_q    <= IDLE;
                     if (!inval) begin
                        cache_vld_q  <= (CACHE_EN != 0);
                        cache_tag_q  <= mem_addr_q[24:2];
                        cache_data_q <= {mem_dout, lo_q};
                     end
                  end
               end else if (cnt_q == CW'(TIMEOUT)) begin
                  sdr_data_q <= 32'hFFFF_FFFF;
                  sdr_rdy_q  <= 1'b1;
                  err_q      <= 1'b1;
                  mem_rd_q   <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign sdr_data = sdr_data_q;
   assign sdr_rdy  = sdr_rdy_q;
   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;
   assign err      = err_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_sdram_rd_port.sv
// Scoreboard bench for sdram_rd_port: a behavioural SDRAM responder feeds the
// DUT, completions are queued by a monitor and popped against expected words.
module tb_sdram_rd_port;

   typedef struct packed {
      logic        e;
      logic [31:0] d;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [24:1] sdr_addr;
   logic        sdr_req;
   logic [31:0] sdr_data;
   logic        sdr_rdy;
   logic [24:1] mem_addr;
   logic        mem_rd;
   logic        mem_ack;
   logic [15:0] mem_dout;
   logic        inval;
   logic        inval_main;
   logic        inval_resp;
   logic        err;
   logic        overflow;

   assign inval = inval_main | inval_resp;

   always #5 clk = ~clk;

   sdram_rd_port #(.CACHE_EN(1), .TIMEOUT(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .sdr_addr (sdr_addr),
      .sdr_req  (sdr_req),
      .sdr_data (sdr_data),
      .sdr_rdy  (sdr_rdy),
      .mem_addr (mem_addr),
      .mem_rd   (mem_rd),
      .mem_ack  (mem_ack),
      .mem_dout (mem_dout),
      .inval    (inval),
      .err      (err),
      .overflow (overflow)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          stray_err = 0;
   logic [15:0] mem_arr [0:1023];
   logic [24:1] addr_log [$];
   obs_t        obs_q [$];
   obs_t        exp_q [$];

   int mem_wait    = 0;
   bit mute        = 1'b0;
   bit hi_block    = 1'b0;
   bit inval_on_hi = 1'b0;

   function automatic logic [31:0] exp_word(input logic [24:1] a);
      logic [9:0] lo_i;
      logic [9:0] hi_i;
      lo_i = {a[10:2], 1'b0};
      hi_i = {a[10:2], 1'b1};
      return {mem_arr[hi_i], mem_arr[lo_i]};
   endfunction

   // SDRAM controller model: acks after mem_wait idle cycles per beat.
   initial begin
      int wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_dout = '0;
      inval_resp = 1'b0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         inval_resp = 1'b0;
         if (mem_rd && !reset) begin
            if (!mute && !(hi_block && mem_addr[1]) && wcnt >= mem_wait) begin
               mem_ack  = 1'b1;
               mem_dout = mem_arr[mem_addr[10:1]];
               addr_log.push_back(mem_addr);
               wcnt = 0;
               if (inval_on_hi && mem_addr[1])
                  inval_resp = 1'b1;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (sdr_rdy) begin
            obs_q.push_back({err, sdr_data});
            $display("[%0t] rdy data=%h err=%b", $time, sdr_data, err);
         end else if (err) begin
            stray_err++;
         end
      end
   end

   task automatic send_req(input logic [24:1] a);
      @(negedge clk);
      sdr_addr = a;
      sdr_req  = 1'b1;
      @(negedge clk);
      sdr_req  = 1'b0;
   endtask

   task automatic wait_rdy(input int bound, output int waited, output bit got);
      waited = 0;
      got = (obs_q.size() > 0);
      while (!got && waited < bound) begin
         @(negedge clk);
         #1;
         waited++;
         got = (obs_q.size() > 0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sdr_req = 1'b0;
      sdr_addr = '0;
      inval_main = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sdr_data, sdr_rdy, err, overflow} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_sdr: data=%h rdy=%b err=%b ovf=%b, required all 0", sdr_data, sdr_rdy, err, overflow);
      end
      n_checks++;
      if ({mem_addr, mem_rd} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_mem: addr=%h rd=%b, required 0", mem_addr, mem_rd);
      end
      reset = 1'b0;
   endtask

   task automatic test_miss();
      int w; bit got; obs_t o, e;
      addr_log.delete();
      exp_q.push_back({1'b0, 32'hABCD1234});
      send_req(24'h000100);
      wait_rdy(20, w, got);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL miss_rdy: no sdr_rdy within 20 cycles");
         void'(exp_q.pop_front());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL miss_data: got %h expected %h", o, e); end
         n_checks++;
         if (w + 1 != 3) begin n_fail++; $display("FAIL miss_latency: got %0d cycles expected 3", w + 1); end
      end
      n_checks++;
      if (addr_log.size() != 2 || addr_log[0] !== 24'h000100 || addr_log[1] !== 24'h000101) begin
         n_fail++;
         $display("FAIL miss_addr: %0d beats, first %h, required 000100 then 000101",
                  addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 24'h0);
      end
   endtask

   task automatic test_cache_hit();
      int w; bit got; obs_t o, e;
      addr_log.delete();
      exp_q.push_back({1'b0, 32'hABCD1234});
      send_req(24'h000101);
      #1;
      n_checks++;
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL hit_latency: %0d completions after 1 cycle, required 1", obs_q.size());
         void'(exp_q.pop_front());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL hit_data: got %h expected %h", o, e); end
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (addr_log.size() != 0 || mem_rd !== 1'b0) begin
         n_fail++; $display("FAIL hit_no_sdram: beats=%0d mem_rd=%b, required 0 and 0", addr_log.size(), mem_rd);
      end
      inval_main = 1'b1;
      @(negedge clk);
      inval_main = 1'b0;
      exp_q.push_back({1'b0, exp_word(24'h000101)});
      send_req(24'h000101);
      wait_rdy(20, w, got);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL inval_rdy: no sdr_rdy within 20 cycles");
         void'(exp_q.pop_front());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL inval_data: got %h expected %h", o, e); end
      end
      n_checks++;
      if (addr_log.size() != 2) begin
         n_fail++; $display("FAIL inval_miss: %0d SDRAM beats, required 2", addr_log.size());
      end
   endtask

   task automatic test_back_to_back();
      int w; bit got; obs_t o, e;
      logic [24:1] exp_addrs [4];
      exp_addrs[0] = 24'h000200; exp_addrs[1] = 24'h000201;
      exp_addrs[2] = 24'h000300; exp_addrs[3] = 24'h000301;
      addr_log.delete();
      mem_wait = 3;
      exp_q.push_back({1'b0, exp_word(24'h000200)});
      exp_q.push_back({1'b0, exp_word(24'h000300)});
      @(negedge clk);
      sdr_addr = 24'h000200; sdr_req = 1'b1;
      @(negedge clk);
      sdr_addr = 24'h000300;
      @(negedge clk);
      sdr_addr = 24'h000400;
      @(negedge clk);
      sdr_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wait_rdy(60, w, got);
         n_checks++;
         if (!got) begin
            n_fail++; $display("FAIL queue_rdy%0d: no sdr_rdy within 60 cycles", k);
            void'(exp_q.pop_front());
         end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL queue_data%0d: got %h expected %h", k, o, e); end
            if (k == 1) begin
               n_checks++;
               if (w < 2) begin n_fail++; $display("FAIL queue_spacing: got %0d cycles required >= 2", w); end
            end
         end
      end
      mem_wait = 0;
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL queue_overflow: got %b expected 1", overflow); end
      repeat (10) @(negedge clk);
      #1;
      n_checks++;
      if (obs_q.size() != 0 || mem_rd !== 1'b0) begin
         n_fail++; $display("FAIL queue_drop: extra completions=%0d mem_rd=%b, required 0 and 0", obs_q.size(), mem_rd);
      end
      n_checks++;
      if (addr_log.size() != 4) begin
         n_fail++; $display("FAIL queue_beats: got %0d beats expected 4", addr_log.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (addr_log[k] !== exp_addrs[k]) begin
               n_fail++; $display("FAIL queue_addr%0d: got %h expected %h", k, addr_log[k], exp_addrs[k]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int w; bit got; obs_t o, e;
      mute = 1'b1;
      exp_q.push_back({1'b1, 32'hFFFF_FFFF});
      send_req(24'h000600);
      wait_rdy(40, w, got);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL timeout_rdy: no sdr_rdy within 40 cycles");
         void'(exp_q.pop_front());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL timeout_data: got %h expected %h", o, e); end
         n_checks++;
         if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL timeout_mem_rd: got %b expected 0", mem_rd); end
      end
      mute = 1'b0;
      exp_q.push_back({1'b0, exp_word(24'h000604)});
      send_req(24'h000604);
      wait_rdy(20, w, got);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL after_timeout_rdy: no sdr_rdy within 20 cycles");
         void'(exp_q.pop_front());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL after_timeout_data: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      int w; bit got; bit seen; obs_t o, e;
      exp_q.push_back({1'b0, exp_word(24'h000500)});
      send_req(24'h000500);
      wait_rdy(20, w, got);
      if (got) void'(obs_q.pop_front());
      void'(exp_q.pop_front());
      hi_block = 1'b1;
      send_req(24'h000400);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (mem_rd && mem_addr[1]) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL reset_mid_reach: RD_HI beat never requested"); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_async_mem_rd: got %b expected 0", mem_rd); end
      n_checks++;
      if ({sdr_data, sdr_rdy, mem_addr, err, overflow} !== 59'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: data=%h rdy=%b addr=%h err=%b ovf=%b, required all 0",
                  sdr_data, sdr_rdy, mem_addr, err, overflow);
      end
      hi_block = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      n_checks++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL reset_no_rdy: got %0d completions expected 0", obs_q.size());
         obs_q.delete();
      end
      addr_log.delete();
      exp_q.push_back({1'b0, exp_word(24'h000500)});
      send_req(24'h000500);
      wait_rdy(20, w, got);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL reset_refetch_rdy: no sdr_rdy within 20 cycles");
         void'(exp_q.pop_front());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL reset_refetch_data: got %h expected %h", o, e); end
      end
      n_checks++;
      if (addr_log.size() != 2) begin
         n_fail++; $display("FAIL reset_cache_cleared: got %0d beats expected 2", addr_log.size());
      end
   endtask

   task automatic test_inval_race();
      int w; bit got; obs_t o, e;
      for (int pass = 0; pass < 2; pass++) begin
         inval_on_hi = (pass == 0);
         addr_log.delete();
         exp_q.push_back({1'b0, exp_word(24'h000700)});
         send_req(24'h000700);
         wait_rdy(20, w, got);
         n_checks++;
         if (!got) begin
            n_fail++; $display("FAIL race_rdy%0d: no sdr_rdy within 20 cycles", pass);
            void'(exp_q.pop_front());
         end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL race_data%0d: got %h expected %h", pass, o, e); end
         end
         n_checks++;
         if (addr_log.size() != 2) begin
            n_fail++; $display("FAIL race_miss%0d: got %0d beats expected 2", pass, addr_log.size());
         end
      end
      inval_on_hi = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = 16'($urandom);
      mem_arr[10'h100] = 16'h1234;
      mem_arr[10'h101] = 16'hABCD;
      test_reset();
      test_miss();
      test_cache_hit();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_inval_race();
      n_checks++;
      if (stray_err != 0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL final: stray err pulses=%0d unmatched expectations=%0d, required 0 and 0",
                            stray_err, exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "simulation time limit");
   end

endmodule
